spectrum_peak_detect: RTL and testbench

Downstream consumer of the FFT magnitude stream. The FFT stage produces 64 IEEE-754 single-precision magnitude-squared values per window, one per clock, in natural bin order. This block scans each window for the largest bin and counts the bins above a programmable threshold. It then holds the per-window result until the next stage acknowledges it.

---
 rtl/spectrum_peak_detect.sv | 131 +++++++++++++
 tb/tb_spectrum_peak_detect.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_detect.sv
// spectrum_peak_detect: per-window peak search and threshold count over an
// FFT magnitude-squared stream, with a held result and ready/valid output.
module spectrum_peak_detect #(
    parameter int unsigned SIZE    = 64,
    parameter int unsigned BIN_W   = 6,
    parameter bit          SKIP_DC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [31:0]      in_data,
    input  logic [31:0]      threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] peak_bin,
    output logic [31:0]      peak_value,
    output logic [BIN_W:0]   over_count,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned          CNT_W    = BIN_W + 1;
    localparam int unsigned          KEY_W    = 31;
    localparam logic [CNT_W-1:0]     LAST_BIN = CNT_W'(SIZE - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bin_cnt;
    logic [KEY_W-1:0]   run_max;
    logic [BIN_W-1:0]   run_bin;
    logic [CNT_W-1:0]   run_cnt;
    logic [KEY_W-1:0]   thr;

    logic [KEY_W-1:0]   cand_c;
    logic [KEY_W-1:0]   thr_in_c;
    logic               start_c;
    logic               beat_c;
    logic               last_c;
    logic [KEY_W-1:0]   first_max_c;
    logic [CNT_W-1:0]   first_cnt_c;
    logic [KEY_W-1:0]   nxt_max_c;
    logic [BIN_W-1:0]   nxt_bin_c;
    logic [CNT_W-1:0]   nxt_cnt_c;

    // Non-negative floats order like unsigned ints; negatives and NaN map to +0.
    function automatic logic [KEY_W-1:0] to_key(input logic [31:0] x);
        logic is_nan;
        is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        return (x[31] || is_nan) ? KEY_W'(0) : x[30:0];
    endfunction

    // Beat classification and running peak/count update for the current sample.
    always_comb begin
        cand_c      = to_key(in_data);
        thr_in_c    = to_key(threshold);
        start_c     = in_valid && in_first;
        beat_c      = in_valid && !in_first && (state == COLLECT);
        last_c      = beat_c && (bin_cnt == LAST_BIN);
        first_max_c = cand_c;
        first_cnt_c = CNT_W'(cand_c > thr_in_c);
        if (SKIP_DC) begin
            first_max_c = KEY_W'(0);
            first_cnt_c = CNT_W'(0);
        end
        nxt_max_c = run_max;
        nxt_bin_c = run_bin;
        if (cand_c > run_max) begin
            nxt_max_c = cand_c;
            nxt_bin_c = bin_cnt[BIN_W-1:0];
        end
        nxt_cnt_c = run_cnt + CNT_W'(cand_c > thr);
    end

    // Window FSM, running registers, held result and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            run_max    <= '0;
            run_bin    <= '0;
            run_cnt    <= '0;
            thr        <= '0;
            out_valid  <= 1'b0;
            peak_bin   <= '0;
            peak_value <= '0;
            over_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (last_c) begin
                peak_bin   <= nxt_bin_c;
                peak_value <= {1'b0, nxt_max_c};
                over_count <= nxt_cnt_c;
                out_valid  <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (start_c) begin
                if (state == COLLECT) begin
                    frame_err <= 1'b1;
                end
                state   <= COLLECT;
                bin_cnt <= CNT_W'(1);
                run_max <= first_max_c;
                run_bin <= '0;
                run_cnt <= first_cnt_c;
                thr     <= thr_in_c;
            end else if (beat_c) begin
                run_max <= nxt_max_c;
                run_bin <= nxt_bin_c;
                run_cnt <= nxt_cnt_c;
                if (last_c) begin
                    state   <= IDLE;
                    bin_cnt <= '0;
                end else begin
                    bin_cnt <= bin_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_detect.sv
// Testbench for spectrum_peak_detect: directed and random windows checked
// against an array-based reference model, for SKIP_DC = 1 and SKIP_DC = 0.
module tb_spectrum_peak_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [31:0] in_data = '0;
    logic [31:0] threshold = '0;
    logic        out_ready = 1'b0;

    logic        o_valid, o_ferr, o_ovr;
    logic [5:0]  o_bin;
    logic [31:0] o_val;
    logic [6:0]  o_cnt;
    logic        z_valid, z_ferr, z_ovr;
    logic [5:0]  z_bin;
    logic [31:0] z_val;
    logic [6:0]  z_cnt;

    logic [31:0] win [64];
    logic [31:0] cur_thr;
    int          errors = 0;
    int          checks = 0;
    int          xfer = 0;
    int          x0;

    always #5 clk = ~clk;

    spectrum_peak_detect #(.SIZE(64), .BIN_W(6), .SKIP_DC(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_data(in_data), .threshold(threshold), .out_valid(o_valid),
        .out_ready(out_ready), .peak_bin(o_bin), .peak_value(o_val),
        .over_count(o_cnt), .frame_err(o_ferr), .overrun(o_ovr)
    );

    spectrum_peak_detect #(.SIZE(64), .BIN_W(6), .SKIP_DC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_data(in_data), .threshold(threshold), .out_valid(z_valid),
        .out_ready(out_ready), .peak_bin(z_bin), .peak_value(z_val),
        .over_count(z_cnt), .frame_err(z_ferr), .overrun(z_ovr)
    );

    // Count result transfers of the SKIP_DC = 1 instance.
    always @(posedge clk) begin
        if (o_valid && out_ready) xfer <= xfer + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Magnitude as an ordered integer: negative samples and NaN count as zero.
    function automatic logic [30:0] mag(input logic [31:0] x);
        if (x[31]) return 31'd0;
        if ((&x[30:23]) && (|x[22:0])) return 31'd0;
        return x[30:0];
    endfunction

    // Integer k as a single-precision bit pattern.
    function automatic logic [31:0] f_int(input int k);
        int p;
        if (k == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 31; i++) if (k[i]) p = i;
        return {1'b0, 8'(127 + p), 23'(k << (23 - p))};
    endfunction

    // Reference: lowest-index maximum over the window and count above threshold.
    task automatic model(input bit skip, output logic [5:0] pb,
                         output logic [31:0] pv, output logic [6:0] oc);
        logic [30:0] keys [64];
        logic [30:0] mx;
        bit          found;
        mx = 31'd0;
        for (int k = 0; k < 64; k++) begin
            keys[k] = (skip && k == 0) ? 31'd0 : mag(win[k]);
            if (keys[k] > mx) mx = keys[k];
        end
        found = 1'b0;
        pb = 6'd0;
        for (int k = 0; k < 64; k++) begin
            if (!found && keys[k] == mx) begin
                pb = 6'(k);
                found = 1'b1;
            end
        end
        oc = 7'd0;
        for (int k = 0; k < 64; k++) begin
            if (!(skip && k == 0) && mag(win[k]) > mag(cur_thr)) oc = oc + 7'd1;
        end
        pv = {1'b0, mx};
    endtask

    task automatic check_res(input string tag);
        logic [5:0]  pb;
        logic [31:0] pv;
        logic [6:0]  oc;
        model(1'b1, pb, pv, oc);
        chk({tag, "_bin"}, 32'(o_bin), 32'(pb));
        chk({tag, "_val"}, o_val, pv);
        chk({tag, "_cnt"}, 32'(o_cnt), 32'(oc));
        model(1'b0, pb, pv, oc);
        chk({tag, "_bin0"}, 32'(z_bin), 32'(pb));
        chk({tag, "_val0"}, z_val, pv);
        chk({tag, "_cnt0"}, 32'(z_cnt), 32'(oc));
    endtask

    // Stream n bins of win[]; optional random gaps and mid-window threshold noise.
    task automatic send(input int n, input bit gaps, input int ready_last);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid  = 1'b0;
                    in_first  = 1'($urandom);
                    in_data   = $urandom;
                    threshold = $urandom;
                end
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_first  = (k == 0);
            in_data   = win[k];
            threshold = (k == 0 || !gaps) ? cur_thr : $urandom;
            if (k == n - 1 && ready_last >= 0) out_ready = 1'(ready_last);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic rand_win();
        for (int k = 0; k < 64; k++) begin
            case ($urandom_range(0, 19))
                0:       win[k] = {1'b0, 8'hFF, 23'($urandom) | 23'd1};
                1:       win[k] = {1'b1, 31'($urandom)};
                2:       win[k] = ($urandom_range(0, 3) == 0) ? 32'h7F800000 : 32'd0;
                3:       win[k] = 32'd0;
                4, 5:    win[k] = (k > 0) ? win[k-1] : 32'd0;
                default: win[k] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
            endcase
        end
        cur_thr = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_bin"},   32'(o_bin),   32'd0);
        chk({tag, "_val"},   o_val,        32'd0);
        chk({tag, "_cnt"},   32'(o_cnt),   32'd0);
        chk({tag, "_ferr"},  32'(o_ferr),  32'd0);
        chk({tag, "_ovr"},   32'(o_ovr),   32'd0);
        chk({tag, "_valid0"}, 32'(z_valid), 32'd0);
        chk({tag, "_ovr0"},   32'(z_ovr),   32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        out_ready = 1'b1;

        // Stray beats without in_first are dropped in IDLE
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_first = 1'b0;
            in_data  = 32'h42000000;
        end
        idle_cycle();
        idle_cycle();
        chk("stray_valid", 32'(o_valid), 32'd0);
        chk("stray_ferr",  32'(o_ferr),  32'd0);

        // Ramp window, threshold 1.0
        for (int k = 0; k < 64; k++) win[k] = f_int(k);
        cur_thr = 32'h3F800000;
        x0 = xfer;
        send(64, 1'b0, -1);
        idle_cycle();
        chk("ramp_latency", 32'(o_valid), 32'd1);
        chk("ramp_bin_k", 32'(o_bin), 32'd63);
        chk("ramp_val_k", o_val, 32'h427C0000);
        chk("ramp_cnt_k", 32'(o_cnt), 32'd62);
        check_res("ramp");
        idle_cycle();
        chk("ramp_drop", 32'(o_valid), 32'd0);
        chk("ramp_xfer", 32'(xfer - x0), 32'd1);

        // Ties and DC handling
        for (int k = 0; k < 64; k++) win[k] = 32'h3F800000;
        win[0] = 32'h42C80000;
        win[5] = 32'h41000000;
        win[9] = 32'h41000000;
        send(64, 1'b0, -1);
        idle_cycle();
        chk("tie_bin_k", 32'(o_bin), 32'd5);
        chk("tie_val_k", o_val, 32'h41000000);
        chk("tie_bin0_k", 32'(z_bin), 32'd0);
        check_res("tie");

        // Special values: NaN, negative, then +Inf
        for (int k = 0; k < 64; k++) win[k] = 32'd0;
        win[3] = 32'h7FC00000;
        win[4] = 32'hC0A00000;
        win[7] = 32'h40000000;
        send(64, 1'b0, -1);
        idle_cycle();
        chk("spec_bin_k", 32'(o_bin), 32'd7);
        chk("spec_cnt_k", 32'(o_cnt), 32'd1);
        check_res("spec");
        win[10] = 32'h7F800000;
        send(64, 1'b0, -1);
        idle_cycle();
        chk("inf_bin_k", 32'(o_bin), 32'd10);
        check_res("inf");

        // Random windows, alternately with gaps
        for (int i = 0; i < 8; i++) begin
            rand_win();
            send(64, 1'(i % 2), -1);
            idle_cycle();
            chk("rand_valid", 32'(o_valid), 32'd1);
            check_res("rand");
        end

        // Framing error: restart at bin 20, then one clean window
        chk("pre_ferr", 32'(o_ferr), 32'd0);
        rand_win();
        idle_cycle();
        x0 = xfer;
        send(20, 1'b0, -1);
        rand_win();
        send(64, 1'b0, -1);
        idle_cycle();
        chk("frame_ferr", 32'(o_ferr), 32'd1);
        chk("frame_ferr0", 32'(z_ferr), 32'd1);
        check_res("frame");
        idle_cycle();
        chk("frame_xfer", 32'(xfer - x0), 32'd1);

        // Ready rises on the completion edge of the next window: no overrun
        out_ready = 1'b0;
        rand_win();
        send(64, 1'b0, -1);
        idle_cycle();
        chk("hold_valid", 32'(o_valid), 32'd1);
        check_res("hold");
        x0 = xfer;
        rand_win();
        send(64, 1'b0, 1);
        idle_cycle();
        chk("edge_ovr", 32'(o_ovr), 32'd0);
        chk("edge_valid", 32'(o_valid), 32'd1);
        chk("edge_xfer1", 32'(xfer - x0), 32'd1);
        check_res("edge");
        idle_cycle();
        chk("edge_drop", 32'(o_valid), 32'd0);
        chk("edge_xfer2", 32'(xfer - x0), 32'd2);

        // Overrun: two back-to-back windows with ready low
        out_ready = 1'b0;
        rand_win();
        send(64, 1'b0, -1);
        rand_win();
        send(64, 1'b0, -1);
        idle_cycle();
        chk("ovr_flag", 32'(o_ovr), 32'd1);
        chk("ovr_flag0", 32'(z_ovr), 32'd1);
        check_res("ovr");
        x0 = xfer;
        idle_cycle();
        idle_cycle();
        chk("ovr_held", 32'(o_valid), 32'd1);
        chk("ovr_noxfer", 32'(xfer - x0), 32'd0);
        out_ready = 1'b1;
        idle_cycle();
        chk("ovr_drop", 32'(o_valid), 32'd0);
        repeat (3) idle_cycle();
        chk("ovr_xfer", 32'(xfer - x0), 32'd1);

        // Mid-window reset, then a gapped window
        rand_win();
        send(30, 1'b0, -1);
        @(negedge clk);
        in_data = win[30];
        rst = 1'b0;
        #1;
        chk_zero("rst_now");
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk_zero("rst_held");
        rst = 1'b1;
        x0 = xfer;
        rand_win();
        send(64, 1'b1, -1);
        idle_cycle();
        chk("post_valid", 32'(o_valid), 32'd1);
        chk("post_ferr", 32'(o_ferr), 32'd0);
        chk("post_ovr", 32'(o_ovr), 32'd0);
        check_res("post");
        repeat (2) idle_cycle();
        chk("post_xfer", 32'(xfer - x0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
